mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified memory of the 16-bit multicycle processor between the instruction-fetch path and the load/store data path. Accepts one request at a time from either requester, drives the memory port, waits a fixed memory latency, and returns read data or a write acknowledge to the winner. Ties between requesters are resolved round-robin, so neither side starves. Sits between the control FSM/datapath request strobes and the memory macro.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 2, cycles from `mem_en` to valid `mem_rdata`; must be ≥1

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until `if_gnt`
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant to fetch
- if_rvalid  out  1  one-cycle pulse: `if_rdata` valid
- if_rdata  out  DATA_W  fetched word, registered
- d_req  in  1  data request; held until `d_gnt`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle grant to data
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete
- d_rdata  out  DATA_W  loaded word, registered
- mem_en  out  1  memory access strobe, one cycle
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_en`

## Operation
FSM states:
- IDLE
  - No request: stay in IDLE.
  - Any request: select a winner, assert its gnt plus `mem_en` combinationally in the same cycle, and go to WAIT.
  - `mem_addr`, `mem_we` and `mem_wdata` come from the winner.
  - For a fetch, `mem_we` = 0.
- WAIT
  - Counter `cnt` counts 1..MEM_LAT.
  - When `cnt` == MEM_LAT: capture `mem_rdata` into the winner's rdata register (loads and fetches only) and go to RESP.
- RESP
  - Winner's rvalid = 1 for exactly one cycle, then go to IDLE.

Arbitration:
- Only one requester active: it wins.
- Both active: the requester not recorded in `last_gnt` wins.
- `last_gnt` updates on every grant.

Stores:
- Still pass through WAIT and RESP.
- `d_rvalid` pulses as an acknowledge.
- `d_rdata` keeps its previous value.

Handshake and side rules:
- `req` must stay high with stable address and data until its gnt; it may drop or change from the cycle after gnt.
- A req raised during WAIT or RESP is not granted until the next IDLE cycle.
- A requester may re-request in its own RESP cycle; it is granted in the following IDLE cycle, subject to arbitration.
- `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0 whenever no grant is issued.
- The `if_*` and `d_*` rdata registers are independent; each holds its value until its next captured read.

Reset (async, takes effect immediately mid-operation):
- state = IDLE, `cnt` = 0, `last_gnt` = DATA (so fetch wins the first tie).
- All outputs 0, both rdata registers 0.
- Any in-flight response is dropped; no rvalid is issued for it.

## Timing
- Grant cycle T: gnt and `mem_en` in T.
- Capture at T+MEM_LAT.
- rvalid at T+MEM_LAT+1.
- Next possible grant at T+MEM_LAT+2.
- Peak throughput: one access per MEM_LAT+2 cycles.
- `cnt` width: $clog2(MEM_LAT+1).
- No combinational path from `mem_rdata` to any output.
- Combinational paths exist only from `req`/addr/data to gnt and `mem_*`, in IDLE.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE, WAIT, RESP)
  - requester ID constants (REQ_IF = 0, REQ_D = 1)
- Sub-module `mem_arb_rr2`: two-input round-robin picker, combinational pick plus registered `last_gnt`.
- Top level holds the FSM, counter, winner register, and the rdata capture registers.

## Test plan
- Reset, then `if_req` = 1 at 0x0010 with `mem_rdata` = 0xBEEF (MEM_LAT = 2):
  - `if_gnt` and `mem_en` at T, `mem_addr` = 0x0010, `mem_we` = 0.
  - `if_rvalid` at T+3 with `if_rdata` = 0xBEEF.
- Store, `d_we` = 1, addr 0x0200, wdata 0x1234:
  - `mem_we` = 1 and `mem_wdata` = 0x1234 in the grant cycle.
  - `d_rvalid` pulses at T+3.
  - `d_rdata` unchanged.
- `if_req` and `d_req` both high from reset, held continuously:
  - Grants alternate IF, D, IF, D, spaced 4 cycles apart.
- `d_req` raised during an IF WAIT:
  - No `d_gnt` until the cycle after `if_rvalid`; then `d_gnt` is issued.
- `rst` pulsed during WAIT of a load:
  - Outputs go to 0 immediately and no `d_rvalid` follows.
  - After release, a fetch (`if_req` only) completes normally.
- MEM_LAT = 1 build, back-to-back fetches:
  - `if_rvalid` at T+2 and the next `if_gnt` at T+3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-macro signal bundle around the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory macro view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_rr2.sv
// Two-input round-robin picker: combinational pick, registered last winner.
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if_i,
  input  logic req_d_i,
  input  logic upd_i,
  output logic pick_c_o,
  output logic any_c_o
);

  logic last_q, last_d;

  // On a tie the side that did not win last time goes first
  always_comb begin
    any_c_o = req_if_i | req_d_i;
    if (req_if_i && req_d_i) begin
      pick_c_o = ~last_q;
    end else begin
      pick_c_o = req_d_i ? REQ_D : REQ_IF;
    end
    last_d = upd_i ? pick_c_o : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_D;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store with a fixed-latency
// access sequence IDLE -> WAIT -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned     CNT_W   = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_q, win_d;
  logic              store_q, store_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick;
  logic              any_req;
  logic              grant;

  mem_arb_rr2 u_rr2 (
    .clk      (clk),
    .rst      (rst),
    .req_if_i (bus.if_req),
    .req_d_i  (bus.d_req),
    .upd_i    (grant),
    .pick_c_o (pick),
    .any_c_o  (any_req)
  );

  // Next state and outputs; grant path is gated by rst so outputs drop at once
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    win_d         = win_q;
    store_d       = store_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    grant         = 1'b0;
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.d_rvalid  = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_rdata  = if_rdata_q;
    bus.d_rdata   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (any_req && !rst) begin
          grant      = 1'b1;
          bus.mem_en = 1'b1;
          win_d      = pick;
          cnt_d      = CNT_W'(1);
          state_d    = WAIT;
          if (pick == REQ_IF) begin
            bus.if_gnt   = 1'b1;
            bus.mem_addr = bus.if_addr;
            store_d      = 1'b0;
          end else begin
            bus.d_gnt     = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            store_d       = bus.d_we;
          end
        end
      end
      WAIT: begin
        if (cnt_q == LAT_CNT) begin
          state_d = RESP;
          cnt_d   = '0;
          if (win_q == REQ_IF) begin
            if_rdata_d = bus.mem_rdata;
          end else if (!store_q) begin
            d_rdata_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        bus.if_rvalid = (win_q == REQ_IF);
        bus.d_rvalid  = (win_q == REQ_D);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_q      <= REQ_IF;
      store_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_q      <= win_d;
      store_q    <= store_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=2 instance with a response scoreboard,
// plus a MEM_LAT=1 instance for back-to-back fetch timing.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) a_if ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b_if ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    bit          store;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] exp_wr[logic [7:0]];
  logic [15:0] d_model;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 16'hBEEF : {a, ~a};
  endfunction

  function automatic logic [15:0] exp_mem(input logic [7:0] a);
    return exp_wr.exists(a) ? exp_wr[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model for instance A: read data valid two cycles after mem_en
  logic [1:0]   va;
  logic [7:0]   ad0, ad1;
  logic [255:0] wr_a;
  logic [15:0]  mem_a [256];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      va   <= '0;
      wr_a <= '0;
    end else begin
      va  <= {va[0], a_if.mem_en};
      ad0 <= a_if.mem_addr[7:0];
      ad1 <= ad0;
      if (a_if.mem_en && a_if.mem_we) begin
        mem_a[a_if.mem_addr[7:0]] <= a_if.mem_wdata;
        wr_a[a_if.mem_addr[7:0]]  <= 1'b1;
      end
    end
  end
  assign a_if.mem_rdata = va[1] ? (wr_a[ad1] ? mem_a[ad1] : init_val(ad1)) : 16'hDEAD;

  // Memory model for instance B: read-only, one cycle latency
  logic       vb;
  logic [7:0] adb;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vb <= 1'b0;
    end else begin
      vb  <= b_if.mem_en;
      adb <= b_if.mem_addr[7:0];
    end
  end
  assign b_if.mem_rdata = vb ? init_val(adb) : 16'hDEAD;

  // Scoreboard and idle-bus monitor for instance A
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (a_if.if_gnt || a_if.d_gnt) begin
        check("mem_en_on_gnt", 64'(a_if.mem_en), 64'(1));
      end else begin
        check("mem_idle", 64'({a_if.mem_en, a_if.mem_we, a_if.mem_addr, a_if.mem_wdata}), 64'(0));
      end
      if (a_if.if_rvalid || a_if.d_rvalid) begin
        check("rsp_excl", 64'(a_if.if_rvalid & a_if.d_rvalid), 64'(0));
        if (exp_q.size() == 0) begin
          check("sb_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_port", 64'(a_if.d_rvalid), 64'(e.port));
          if (a_if.if_rvalid) check("if_rdata", 64'(a_if.if_rdata), 64'(e.data));
          else                check("d_rdata", 64'(a_if.d_rdata), 64'(e.data));
        end
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return a_if.if_gnt;
      1:       return a_if.d_gnt;
      2:       return a_if.if_rvalid;
      3:       return a_if.d_rvalid;
      4:       return b_if.if_gnt;
      5:       return b_if.if_rvalid;
      6:       return a_if.if_gnt | a_if.d_gnt;
      default: return 1'b0;
    endcase
  endfunction

  // Returns the cycle of the first negedge where the signal is high, or -1
  task automatic wait_sig(input int sel, input int max, output int t);
    t = -1;
    for (int n = 0; n < max; n++) begin
      @(negedge clk);
      if (sig(sel)) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic req_a(input bit port, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata);
    int tg, tr;
    exp_t x;
    @(posedge clk); #1;
    if (!port) begin
      a_if.if_req  = 1'b1;
      a_if.if_addr = addr;
      x = '{1'b0, 1'b0, exp_mem(addr[7:0])};
    end else begin
      a_if.d_req   = 1'b1;
      a_if.d_we    = we;
      a_if.d_addr  = addr;
      a_if.d_wdata = wdata;
      if (we) begin
        x = '{1'b1, 1'b1, d_model};
        exp_wr[addr[7:0]] = wdata;
      end else begin
        d_model = exp_mem(addr[7:0]);
        x = '{1'b1, 1'b0, d_model};
      end
    end
    exp_q.push_back(x);
    wait_sig(port ? 1 : 0, 20, tg);
    check("gnt_seen", 64'(tg >= 0), 64'(1));
    check("gnt_mem_addr", 64'(a_if.mem_addr), 64'(addr));
    check("gnt_mem_we", 64'(a_if.mem_we), 64'(port & we));
    check("gnt_mem_wdata", 64'(a_if.mem_wdata), port ? 64'(wdata) : 64'(0));
    @(posedge clk); #1;
    a_if.if_req = 1'b0;
    a_if.d_req  = 1'b0;
    a_if.d_we   = 1'b0;
    wait_sig(port ? 3 : 2, 20, tr);
    check("rvalid_lat", 64'(tr - tg), 64'(3));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int t, tp, tg, tr, td;
    rst = 1'b1;
    a_if.if_req = 1'b0; a_if.if_addr = '0;
    a_if.d_req = 1'b0; a_if.d_we = 1'b0; a_if.d_addr = '0; a_if.d_wdata = '0;
    b_if.if_req = 1'b0; b_if.if_addr = '0;
    b_if.d_req = 1'b0; b_if.d_we = 1'b0; b_if.d_addr = '0; b_if.d_wdata = '0;
    d_model = '0;

    // Reset state
    @(negedge clk);
    check("rst_outs", 64'({a_if.if_gnt, a_if.d_gnt, a_if.if_rvalid, a_if.d_rvalid,
                           a_if.mem_en, a_if.mem_we, a_if.mem_addr}), 64'(0));
    check("rst_rdata", 64'({a_if.if_rdata, a_if.d_rdata}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Single fetch, then load / store / load-back
    req_a(1'b0, 1'b0, 16'h0010, 16'h0000);
    req_a(1'b1, 1'b0, 16'h0105, 16'h0000);
    req_a(1'b1, 1'b1, 16'h0200, 16'h1234);
    req_a(1'b1, 1'b0, 16'h0200, 16'h0000);
    check("if_rdata_hold", 64'(a_if.if_rdata), 64'(16'hBEEF));

    // Both requesting from reset: grants alternate IF, D every 4 cycles
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete(); exp_wr.delete(); d_model = '0;
    a_if.if_req = 1'b1; a_if.if_addr = 16'h0020;
    a_if.d_req = 1'b1; a_if.d_we = 1'b0; a_if.d_addr = 16'h0030; a_if.d_wdata = '0;
    @(negedge clk);
    check("rst_gate", 64'({a_if.if_gnt, a_if.d_gnt, a_if.mem_en}), 64'(0));
    d_model = exp_mem(8'h30);
    for (int k = 0; k < 4; k++) begin
      x_push(k[0]);
    end
    @(posedge clk); #1 rst = 1'b0;
    tp = 0;
    for (int k = 0; k < 4; k++) begin
      wait_sig(6, 20, t);
      check("alt_port", 64'(a_if.d_gnt), 64'(k[0]));
      if (k > 0) check("alt_space", 64'(t - tp), 64'(4));
      tp = t;
    end
    @(posedge clk); #1;
    a_if.if_req = 1'b0; a_if.d_req = 1'b0;
    wait_sig(3, 20, t);
    check("alt_last_rvalid", 64'(t >= 0), 64'(1));

    // Data request raised during a fetch WAIT waits for the next IDLE
    @(posedge clk); #1;
    a_if.if_req = 1'b1; a_if.if_addr = 16'h0060;
    exp_q.push_back('{1'b0, 1'b0, exp_mem(8'h60)});
    wait_sig(0, 20, tg);
    @(posedge clk); #1;
    a_if.if_req = 1'b0;
    a_if.d_req = 1'b1; a_if.d_we = 1'b0; a_if.d_addr = 16'h0040;
    d_model = exp_mem(8'h40);
    exp_q.push_back('{1'b1, 1'b0, d_model});
    tr = -1; td = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (a_if.if_rvalid) tr = cyc;
      if (a_if.d_gnt) begin
        td = cyc;
        break;
      end
    end
    check("late_if_rvalid", 64'(tr - tg), 64'(3));
    check("late_d_gnt", 64'(td - tg), 64'(4));
    @(posedge clk); #1 a_if.d_req = 1'b0;
    wait_sig(3, 20, t);
    check("late_d_rvalid", 64'(t - td), 64'(3));

    // Reset during a load WAIT drops the response
    @(posedge clk); #1;
    a_if.d_req = 1'b1; a_if.d_we = 1'b0; a_if.d_addr = 16'h0050;
    exp_q.push_back('{1'b1, 1'b0, exp_mem(8'h50)});
    wait_sig(1, 20, tg);
    @(posedge clk); #1 a_if.d_req = 1'b0;
    #2 rst = 1'b1;
    exp_q.delete(); exp_wr.delete(); d_model = '0;
    #1;
    check("midrst_outs", 64'({a_if.if_gnt, a_if.d_gnt, a_if.if_rvalid, a_if.d_rvalid,
                              a_if.mem_en, a_if.mem_we, a_if.mem_addr}), 64'(0));
    check("midrst_rdata", 64'({a_if.if_rdata, a_if.d_rdata}), 64'(0));
    @(posedge clk); #1 rst = 1'b0;
    wait_sig(3, 8, t);
    check("no_rvalid_after_rst", 64'(t), 64'(-1));
    req_a(1'b0, 1'b0, 16'h0070, 16'h0000);

    // MEM_LAT=1 instance: back-to-back fetches
    @(posedge clk); #1;
    b_if.if_req = 1'b1; b_if.if_addr = 16'h0011;
    wait_sig(4, 20, tg);
    check("b_gnt_addr", 64'(b_if.mem_addr), 64'(16'h0011));
    @(posedge clk); #1 b_if.if_addr = 16'h0012;
    wait_sig(5, 10, tr);
    check("b_rvalid_lat", 64'(tr - tg), 64'(2));
    check("b_rdata0", 64'(b_if.if_rdata), 64'(init_val(8'h11)));
    wait_sig(4, 10, t);
    check("b_next_gnt", 64'(t - tg), 64'(3));
    @(posedge clk); #1 b_if.if_req = 1'b0;
    wait_sig(5, 10, tr);
    check("b_rvalid_lat2", 64'(tr - t), 64'(2));
    check("b_rdata1", 64'(b_if.if_rdata), 64'(init_val(8'h12)));

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Expected response for the alternating-grant sequence (0 = fetch at 0x20, 1 = load at 0x30)
  task automatic x_push(input bit port);
    if (port) exp_q.push_back('{1'b1, 1'b0, d_model});
    else      exp_q.push_back('{1'b0, 1'b0, exp_mem(8'h20)});
  endtask

endmodule
